// File: rtl/elastic_pipeline_reg_pkg.sv
// elastic_pipeline_reg_pkg: shared depth limit and pointer wrap helper for elastic stages
package elastic_pipeline_reg_pkg;
   localparam int MAX_ELASTIC_DEPTH = 16;
   // Wraps at depth-1 so non-power-of-two depths need no modulo hardware.
   function automatic logic [3:0] next_ptr(input logic [3:0] ptr, input int depth);
      return (int'(ptr) == depth - 1) ? 4'd0 : ptr + 4'd1;
   endfunction
endpackage

// File: rtl/elastic_pipeline_reg.sv
// elastic_pipeline_reg: DEPTH-entry valid/ready pipeline register with flush and NOP-when-empty output
module elastic_pipeline_reg
   import elastic_pipeline_reg_pkg::*;
#(
   parameter type T = logic,
   parameter T NOP = '0,
   parameter int DEPTH = 2,
   parameter int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  T              signals_in,
   output logic          out_valid,
   input  logic          out_ready,
   output T              signals_out,
   output logic [CW-1:0] count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   T mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic push, pop;
   // Ready/valid come only from count, so no combinational path crosses the stage.
   assign in_ready = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign signals_out = out_valid ? mem[rd_ptr] : NOP;
   assign push = in_valid & in_ready & ~flush;
   assign pop = out_valid & out_ready & ~flush;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         mem <= '{default: NOP};
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         mem <= '{default: NOP};
      end else begin
         if (push) begin
            mem[wr_ptr] <= signals_in;
            wr_ptr <= PW'(next_ptr(4'(wr_ptr), DEPTH));
         end
         // Scrub the popped slot so stale payloads never resurface.
         if (pop) begin
            mem[rd_ptr] <= NOP;
            rd_ptr <= PW'(next_ptr(4'(rd_ptr), DEPTH));
         end
         count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
      end
endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// tb_elastic_pipeline_reg: scoreboard bench over DEPTH 1..4 instances of elastic_pipeline_reg
module tb_elastic_pipeline_reg;
   logic clk = 0;
   logic reset_n = 0;
   logic iv [4], ordy [4], fl [4], irdy [4], ov [4];
   logic [7:0] din [4], dout [4];
   logic [0:0] cnt_1;
   logic [1:0] cnt_2, cnt_3;
   logic [2:0] cnt_4;
   logic [4:0] cntx [4];
   int depth_of [4] = '{1, 2, 3, 4};
   int cur = 1;
   int mcount = 0;
   int checks = 0;
   int passed = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;
   assign cntx[0] = 5'(cnt_1);
   assign cntx[1] = 5'(cnt_2);
   assign cntx[2] = 5'(cnt_3);
   assign cntx[3] = 5'(cnt_4);

   elastic_pipeline_reg #(.T(logic [7:0]), .NOP(8'h00), .DEPTH(1)) u_d1 (
      .clk(clk), .reset_n(reset_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
      .signals_in(din[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .signals_out(dout[0]), .count(cnt_1));
   elastic_pipeline_reg #(.T(logic [7:0]), .NOP(8'h00), .DEPTH(2)) u_d2 (
      .clk(clk), .reset_n(reset_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
      .signals_in(din[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .signals_out(dout[1]), .count(cnt_2));
   elastic_pipeline_reg #(.T(logic [7:0]), .NOP(8'h00), .DEPTH(3)) u_d3 (
      .clk(clk), .reset_n(reset_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
      .signals_in(din[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .signals_out(dout[2]), .count(cnt_3));
   elastic_pipeline_reg #(.T(logic [7:0]), .NOP(8'h00), .DEPTH(4)) u_d4 (
      .clk(clk), .reset_n(reset_n), .flush(fl[3]), .in_valid(iv[3]), .in_ready(irdy[3]),
      .signals_in(din[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .signals_out(dout[3]), .count(cnt_4));

   // Reference model: occupancy counter plus expected-output queue for the active instance.
   always @(negedge clk) begin
      logic push, pop;
      logic [7:0] exp_v;
      if (!reset_n) begin
         sb.delete();
         mcount = 0;
      end else begin
         checks++;
         if (cntx[cur] !== 5'(mcount)) $display("FAIL model_count d%0d got %0d want %0d", depth_of[cur], cntx[cur], mcount);
         else passed++;
         checks++;
         if (irdy[cur] !== (mcount != depth_of[cur])) $display("FAIL model_in_ready d%0d got %0b want %0b", depth_of[cur], irdy[cur], mcount != depth_of[cur]);
         else passed++;
         checks++;
         if (ov[cur] !== (mcount != 0)) $display("FAIL model_out_valid d%0d got %0b want %0b", depth_of[cur], ov[cur], mcount != 0);
         else passed++;
         if (mcount == 0) begin
            checks++;
            if (dout[cur] !== 8'h00) $display("FAIL empty_nop d%0d got %0h want 00", depth_of[cur], dout[cur]);
            else passed++;
         end
         if (fl[cur]) begin
            sb.delete();
            mcount = 0;
         end else begin
            pop = ov[cur] && ordy[cur];
            push = iv[cur] && irdy[cur];
            assert (!(push && mcount == depth_of[cur]));
            if (pop) begin
               checks++;
               if (sb.size() == 0) $display("FAIL unexpected_output d%0d got %0h want none", depth_of[cur], dout[cur]);
               else begin
                  exp_v = sb.pop_front();
                  if (dout[cur] !== exp_v) $display("FAIL scoreboard d%0d got %0h want %0h", depth_of[cur], dout[cur], exp_v);
                  else passed++;
               end
            end
            if (push) sb.push_back(din[cur]);
            mcount = mcount + int'(push) - int'(pop);
            assert (mcount <= depth_of[cur]);
         end
      end
   end

   task automatic select(input int d);
      cur = d;
      mcount = 0;
      sb.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (ov[1] !== 1'b0 || irdy[1] !== 1'b1 || cnt_2 !== 2'd0 || dout[1] !== 8'h00)
         $display("FAIL reset_state got ov=%0b ir=%0b cnt=%0d out=%0h want 0 1 0 00", ov[1], irdy[1], cnt_2, dout[1]);
      else passed++;
      repeat (2) tick();
      reset_n = 1;
      iv[1] = 1; din[1] = 8'h0A;
      tick();
      din[1] = 8'h0B;
      tick();
      iv[1] = 0;
      checks++;
      if (cnt_2 !== 2'd2) $display("FAIL pre_reset_count got %0d want 2", cnt_2);
      else passed++;
      reset_n = 0;
      #1;
      checks++;
      if (ov[1] !== 1'b0 || dout[1] !== 8'h00 || cnt_2 !== 2'd0 || irdy[1] !== 1'b1)
         $display("FAIL async_reset got ov=%0b out=%0h cnt=%0d ir=%0b want 0 00 0 1", ov[1], dout[1], cnt_2, irdy[1]);
      else passed++;
      tick();
      reset_n = 1;
      iv[1] = 1; din[1] = 8'hA1;
      tick();
      iv[1] = 0;
      checks++;
      if (ov[1] !== 1'b1 || dout[1] !== 8'hA1) $display("FAIL post_reset_latency got ov=%0b out=%0h want 1 a1", ov[1], dout[1]);
      else passed++;
      ordy[1] = 1;
      tick();
      ordy[1] = 0;
   endtask

   task automatic test_stream();
      select(1);
      ordy[1] = 1;
      for (int i = 1; i <= 8; i++) begin
         iv[1] = 1; din[1] = 8'(i);
         checks++;
         if (irdy[1] !== 1'b1) $display("FAIL stream_in_ready i=%0d got %0b want 1", i, irdy[1]);
         else passed++;
         tick();
         checks++;
         if (ov[1] !== 1'b1 || dout[1] !== 8'(i)) $display("FAIL stream_out i=%0d got %0b/%0h want 1/%0h", i, ov[1], dout[1], i);
         else passed++;
      end
      iv[1] = 0;
      tick();
      checks++;
      if (ov[1] !== 1'b0) $display("FAIL stream_drain got %0b want 0", ov[1]);
      else passed++;
      ordy[1] = 0;
   endtask

   task automatic test_backpressure();
      logic took;
      select(2);
      ordy[2] = 0;
      for (int i = 0; i < 3; i++) begin
         iv[2] = 1; din[2] = 8'h10 + 8'(i);
         tick();
      end
      din[2] = 8'h13;
      checks++;
      if (cnt_3 !== 2'd3 || irdy[2] !== 1'b0) $display("FAIL bp_full got cnt=%0d ir=%0b want 3 0", cnt_3, irdy[2]);
      else passed++;
      repeat (2) tick();
      checks++;
      if (cnt_3 !== 2'd3 || dout[2] !== 8'h10) $display("FAIL bp_hold got cnt=%0d out=%0h want 3 10", cnt_3, dout[2]);
      else passed++;
      ordy[2] = 1;
      took = 0;
      for (int k = 0; k < 8 && !took; k++) begin
         took = irdy[2];
         tick();
      end
      iv[2] = 0;
      checks++;
      if (!took) $display("FAIL bp_accept_4th got 0 want 1");
      else passed++;
      repeat (5) tick();
      checks++;
      if (ov[2] !== 1'b0 || sb.size() != 0) $display("FAIL bp_drain got ov=%0b left=%0d want 0 0", ov[2], sb.size());
      else passed++;
      ordy[2] = 0;
   endtask

   task automatic test_flush();
      select(3);
      ordy[3] = 0;
      for (int i = 0; i < 3; i++) begin
         iv[3] = 1; din[3] = 8'h30 + 8'(i);
         tick();
      end
      din[3] = 8'h55; ordy[3] = 1; fl[3] = 1;
      tick();
      fl[3] = 0; iv[3] = 0;
      checks++;
      if (cnt_4 !== 3'd0 || ov[3] !== 1'b0 || dout[3] !== 8'h00 || irdy[3] !== 1'b1)
         $display("FAIL flush got cnt=%0d ov=%0b out=%0h ir=%0b want 0 0 00 1", cnt_4, ov[3], dout[3], irdy[3]);
      else passed++;
      repeat (3) tick();
      checks++;
      if (ov[3] !== 1'b0) $display("FAIL flush_no_55 got ov=%0b out=%0h want 0", ov[3], dout[3]);
      else passed++;
      ordy[3] = 0;
   endtask

   task automatic test_wrap();
      select(2);
      for (int c = 0; c < 1000; c++) begin
         iv[2] = 1'($urandom % 2);
         din[2] = 8'($urandom);
         ordy[2] = 1'($urandom % 2);
         tick();
      end
      iv[2] = 0; ordy[2] = 1;
      repeat (5) tick();
      checks++;
      if (sb.size() != 0 || ov[2] !== 1'b0) $display("FAIL wrap_drain got left=%0d ov=%0b want 0 0", sb.size(), ov[2]);
      else passed++;
      ordy[2] = 0;
   endtask

   task automatic test_depth1();
      logic took;
      int accepted = 0;
      select(0);
      ordy[0] = 1; iv[0] = 1; din[0] = 8'h20;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (irdy[0] !== (k % 2 == 0)) $display("FAIL d1_in_ready k=%0d got %0b want %0b", k, irdy[0], k % 2 == 0);
         else passed++;
         took = irdy[0];
         tick();
         if (took) begin
            accepted++;
            din[0] = din[0] + 8'd1;
         end
      end
      iv[0] = 0;
      checks++;
      if (accepted != 4) $display("FAIL d1_throughput got %0d want 4", accepted);
      else passed++;
      repeat (2) tick();
      checks++;
      if (ov[0] !== 1'b0) $display("FAIL d1_drain got %0b want 0", ov[0]);
      else passed++;
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         iv[d] = 0; ordy[d] = 0; fl[d] = 0; din[d] = 0;
      end
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_wrap();
      test_depth1();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
